// File: rtl/arb_req_queue.sv
// Per-requester FIFOs feeding a 4-way round-robin arbiter.
// Pops the granted FIFO and presents the word on one valid/ready output.
module arb_req_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            in_valid,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            in_ready,
    output logic [3:0]            req,
    input  logic [3:0]            grant,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_id,
    input  logic                  out_ready,
    output logic                  grant_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] COOL = 2'd2;

    logic [AW:0]         wr_ptr_q [4];
    logic [AW:0]         wr_ptr_d [4];
    logic [AW:0]         rd_ptr_q [4];
    logic [AW:0]         rd_ptr_d [4];
    logic [DATA_W-1:0]   mem_q    [4][DEPTH];
    logic [1:0]          state_q, state_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [1:0]          out_id_q, out_id_d;
    logic                grant_err_q, grant_err_d;
    logic [3:0]          empty, full, push, pop;
    logic [1:0]          gnt_idx;
    logic                gnt_onehot;
    logic [DATA_W-1:0]   head;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                       (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
        end
    end

    assign in_ready  = ~full;
    assign push      = in_valid & ~full;
    assign req       = (state_q == IDLE) ? ~empty : 4'b0000;
    assign out_valid = (state_q == BUSY);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign grant_err = grant_err_q;

    // Only meaningful when grant is one-hot.
    always_comb begin
        gnt_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) gnt_idx = 2'(i);
        end
    end

    assign gnt_onehot = $onehot(grant);
    assign head       = mem_q[gnt_idx][rd_ptr_q[gnt_idx][AW-1:0]];

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        grant_err_d = grant_err_q;
        pop         = 4'b0000;
        case (state_q)
            IDLE: begin
                if (gnt_onehot && !empty[gnt_idx]) begin
                    pop[gnt_idx] = 1'b1;
                    out_data_d   = head;
                    out_id_d     = gnt_idx;
                    state_d      = BUSY;
                end else if (grant != 4'b0000) begin
                    grant_err_d = 1'b1;
                end
            end
            BUSY: begin
                if (out_ready) state_d = COOL;
            end
            COOL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + {{AW{1'b0}}, push[i]};
            rd_ptr_d[i] = rd_ptr_q[i] + {{AW{1'b0}}, pop[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_id_q    <= 2'd0;
            grant_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            grant_err_q <= grant_err_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue: vector table, directed corner sequences,
// and a randomized run against a queue-based model with a behavioural arbiter.
module tb_arb_req_queue;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic        grant_err;

    logic [3:0]  grant_drv;
    logic        use_arb;
    logic [3:0]  arb_g;
    logic [1:0]  arb_last;
    logic [2:0]  arb_pick;

    int n_chk;
    int n_pass;

    arb_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign grant = use_arb ? arb_g : grant_drv;

    // Behavioural round-robin arbiter with a registered grant.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (int'(last) + k) % 4;
            if (r[j]) return {1'b1, 2'(j)};
        end
        return 3'b000;
    endfunction

    always_comb arb_pick = rr_pick(req, arb_last);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_g    <= 4'b0000;
            arb_last <= 2'd3;
        end else begin
            arb_g <= arb_pick[2] ? (4'b0001 << arb_pick[1:0]) : 4'b0000;
            if (arb_pick[2]) arb_last <= arb_pick[1:0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 4'b0000;
        in_data   = 32'h0;
        grant_drv = 4'b0000;
        out_ready = 1'b1;
        use_arb   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  iv;
        logic [31:0] din;
        logic [3:0]  gnt;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic [3:0]  e_req;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_id;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] iv, input logic [31:0] din,
                                input logic [3:0] gnt, input logic ordy,
                                input logic [3:0] e_req, input logic e_ov,
                                input logic [7:0] e_od, input logic [1:0] e_id);
        vec_t v;
        v.iv = iv; v.din = din; v.gnt = gnt; v.ordy = ordy;
        v.e_rdy = 4'hF; v.e_req = e_req; v.e_ov = e_ov;
        v.e_od = e_od; v.e_id = e_id; v.e_err = 1'b0;
        return v;
    endfunction

    logic [7:0] mq [4][$];

    initial begin
        vec_t tbl [17];
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        do_reset();

        // single push of A5, then backpressure on 0x11 from port 2
        tbl[0]  = mk(4'b0001, 32'h000000A5, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
        tbl[1]  = mk(4'b0000, 32'h0,        4'b0000, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0);
        tbl[2]  = mk(4'b0000, 32'h0,        4'b0001, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0);
        tbl[3]  = mk(4'b0000, 32'h0,        4'b0001, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd0);
        tbl[4]  = mk(4'b0000, 32'h0,        4'b0001, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0);
        tbl[5]  = mk(4'b0000, 32'h0,        4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0);
        tbl[6]  = mk(4'b0100, 32'h00110000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0);
        tbl[7]  = mk(4'b0000, 32'h0,        4'b0000, 1'b1, 4'b0100, 1'b0, 8'hA5, 2'd0);
        tbl[8]  = mk(4'b0000, 32'h0,        4'b0100, 1'b1, 4'b0100, 1'b0, 8'hA5, 2'd0);
        tbl[9]  = mk(4'b0000, 32'h0,        4'b0100, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd2);
        tbl[10] = mk(4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd2);
        tbl[11] = mk(4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd2);
        tbl[12] = mk(4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd2);
        tbl[13] = mk(4'b0000, 32'h0,        4'b0000, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd2);
        tbl[14] = mk(4'b0000, 32'h0,        4'b0000, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd2);
        tbl[15] = mk(4'b0000, 32'h0,        4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd2);
        tbl[16] = mk(4'b0000, 32'h0,        4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd2);

        for (int k = 0; k < 17; k++) begin
            chk($sformatf("v%0d_in_ready", k), in_ready, tbl[k].e_rdy);
            chk($sformatf("v%0d_req", k), req, tbl[k].e_req);
            chk($sformatf("v%0d_out_valid", k), out_valid, tbl[k].e_ov);
            chk($sformatf("v%0d_out_data", k), out_data, tbl[k].e_od);
            chk($sformatf("v%0d_out_id", k), out_id, tbl[k].e_id);
            chk($sformatf("v%0d_grant_err", k), grant_err, tbl[k].e_err);
            in_valid  = tbl[k].iv;
            in_data   = tbl[k].din;
            grant_drv = tbl[k].gnt;
            out_ready = tbl[k].ordy;
            tick();
        end

        // full FIFO and ordering on port 1
        do_reset();
        for (int j = 1; j <= 5; j++) begin
            if (j == 5) chk("full_in_ready1", in_ready[1], 1'b0);
            in_valid = 4'b0010;
            in_data  = 32'(j) << 8;
            tick();
        end
        in_valid = 4'b0000;
        chk("full_req1", req[1], 1'b1);
        for (int j = 0; j < 4; j++) begin
            grant_drv = 4'b0010;
            tick();
            grant_drv = 4'b0000;
            chk($sformatf("order%0d_valid", j), out_valid, 1'b1);
            chk($sformatf("order%0d_data", j), out_data, 32'(j + 1));
            chk($sformatf("order%0d_id", j), out_id, 2'd1);
            if (j == 0) chk("full_ready_back", in_ready[1], 1'b1);
            tick();
            tick();
        end
        chk("full_req1_low", req[1], 1'b0);
        chk("full_err", grant_err, 1'b0);

        // protocol error: grant to empty FIFO
        do_reset();
        grant_drv = 4'b0010;
        tick();
        grant_drv = 4'b0000;
        chk("perr_empty_err", grant_err, 1'b1);
        chk("perr_empty_valid", out_valid, 1'b0);

        // protocol error: two-hot grant, nothing popped
        do_reset();
        in_valid = 4'b0011;
        in_data  = 32'h00002221;
        tick();
        in_valid = 4'b0000;
        tick();
        grant_drv = 4'b0011;
        tick();
        grant_drv = 4'b0000;
        chk("perr_2hot_err", grant_err, 1'b1);
        chk("perr_2hot_valid", out_valid, 1'b0);
        chk("perr_2hot_req", req, 4'b0011);
        grant_drv = 4'b0001;
        tick();
        grant_drv = 4'b0000;
        chk("perr_p0_data", out_data, 8'h21);
        tick();
        tick();
        grant_drv = 4'b0010;
        tick();
        grant_drv = 4'b0000;
        chk("perr_p1_data", out_data, 8'h22);
        tick();
        tick();
        chk("perr_drained", req, 4'b0000);

        // async reset while BUSY
        do_reset();
        grant_drv = 4'b0100;
        tick();
        grant_drv = 4'b0000;
        in_valid  = 4'b1001;
        in_data   = 32'h78000077;
        tick();
        in_valid = 4'b0000;
        tick();
        out_ready = 1'b0;
        grant_drv = 4'b0001;
        tick();
        grant_drv = 4'b0000;
        chk("ares_pre_valid", out_valid, 1'b1);
        chk("ares_pre_err", grant_err, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("ares_valid", out_valid, 1'b0);
        chk("ares_req", req, 4'b0000);
        chk("ares_err", grant_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        chk("ares_in_ready", in_ready, 4'hF);
        chk("ares_req_after", req, 4'b0000);
        tick();
        chk("ares_discard", req, 4'b0000);

        // three requesters through the arbiter
        begin
            logic [7:0] seen [4];
            logic       ovp;
            int         cnt;
            do_reset();
            use_arb  = 1'b1;
            in_valid = 4'b1011;
            in_data  = 32'h30002010;
            tick();
            in_valid = 4'b0000;
            for (int i = 0; i < 4; i++) seen[i] = 8'h00;
            ovp = 1'b0;
            cnt = 0;
            for (int c = 0; c < 40; c++) begin
                if (out_valid && !ovp) begin
                    cnt++;
                    seen[out_id] = out_data;
                end
                ovp = out_valid;
                tick();
            end
            chk("multi_count", cnt, 3);
            chk("multi_p0", seen[0], 8'h10);
            chk("multi_p1", seen[1], 8'h20);
            chk("multi_p2", seen[2], 8'h00);
            chk("multi_p3", seen[3], 8'h30);
            chk("multi_err", grant_err, 1'b0);
        end

        // randomized traffic against queue model
        begin
            logic ovp;
            logic lim;
            int   left;
            do_reset();
            use_arb = 1'b1;
            for (int i = 0; i < 4; i++) mq[i].delete();
            ovp = 1'b0;
            for (int c = 0; c < 2000; c++) begin
                lim = (c < 500);
                if (out_valid && !ovp) begin
                    if (mq[out_id].size() == 0) begin
                        chk("rand_pop_empty", out_id, 3'h4);
                    end else begin
                        chk("rand_data", out_data, mq[out_id].pop_front());
                    end
                end
                ovp = out_valid;
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("rand_in_ready%0d", i), in_ready[i],
                        mq[i].size() < DEPTH);
                end
                chk("rand_err", grant_err, 1'b0);
                if (lim) begin
                    in_valid  = 4'($urandom);
                    in_data   = $urandom;
                    out_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    in_valid  = 4'b0000;
                    out_ready = 1'b1;
                end
                for (int i = 0; i < 4; i++) begin
                    if (in_valid[i] && in_ready[i]) mq[i].push_back(in_data[i*8 +: 8]);
                end
                tick();
                left = mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size();
                if (!lim && left == 0 && !out_valid && !ovp) break;
            end
            left = mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size();
            chk("rand_drained", left, 0);
            chk("rand_idle", out_valid, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
